// File: rtl/sample_sink_sdm_if.sv
// Sample stream handshake between the generator and the audio sink.
// The master side produces samples; the slave side returns pause.
interface sample_sink_sdm_if;
    logic signed [15:0] i_sample;
    logic               i_pulse;
    logic               o_pause;

    modport master (
        output i_sample,
        output i_pulse,
        input  o_pause
    );

    modport slave (
        input  i_sample,
        input  i_pulse,
        output o_pause
    );
endinterface

// File: rtl/sample_sink_sdm.sv
// Audio sink: sample FIFO, frame pacing, prime/run FSM, 1st-order SDM DAC.
// Optional SAMPLE_SINK_STATS_EN adds saturating underflow/overflow counters.
module sample_sink_sdm #(
    parameter int FIFO_DEPTH   = 16,
    parameter int PAUSE_LEVEL  = 12,
    parameter int PRIME_LEVEL  = 8,
    parameter int FRAME_CYCLES = 1000
) (
    input  logic                          i_clk48,
    input  logic                          i_rst48_n,
    sample_sink_sdm_if.slave              bus,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_running,
    output logic                          o_frame,
    output logic                          o_underflow,
    output logic                          o_overflow,
    output logic                          o_dac
`ifdef SAMPLE_SINK_STATS_EN
    ,
    output logic [15:0]                   o_underflow_cnt,
    output logic [15:0]                   o_overflow_cnt
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

    typedef enum logic {PRIME, RUN} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [15:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  frame_cnt;
    logic [15:0]    cur;
    logic [15:0]    acc;
    logic [16:0]    sum;
    logic           tick;
    logic           full;
    logic           wr;
    logic           pop;
    logic           uflow;
    logic           mute;

    assign tick      = (frame_cnt == CW'(FRAME_CYCLES - 1));
    assign full      = (o_level == LW'(FIFO_DEPTH));
    assign wr        = bus.i_pulse && !full;
    assign o_running = (state == RUN);
    assign sum       = {1'b0, acc} + {1'b0, ~cur[15], cur[14:0]};

    // State register for the prime/run controller.
    always_ff @(posedge i_clk48) begin
        if (!i_rst48_n) begin
            state <= PRIME;
        end else begin
            state <= state_nxt;
        end
    end

    // Boundary decisions: leave PRIME with a pop, pop or underflow in RUN.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        uflow     = 1'b0;
        mute      = 1'b0;
        unique case (state)
            PRIME: begin
                mute = 1'b1;
                if (tick && o_level >= LW'(PRIME_LEVEL)) begin
                    state_nxt = RUN;
                    mute      = 1'b0;
                    pop       = (o_level != '0);
                end
            end
            RUN: begin
                if (tick) begin
                    if (o_level != '0) begin
                        pop = 1'b1;
                    end else begin
                        uflow     = 1'b1;
                        mute      = 1'b1;
                        state_nxt = PRIME;
                    end
                end
            end
            default: state_nxt = PRIME;
        endcase
    end

    // Sample storage; contents are don't-care once pointers reset.
    always_ff @(posedge i_clk48) begin
        if (i_rst48_n && wr) begin
            mem[wr_ptr] <= bus.i_sample;
        end
    end

    // Pointers, level, frame pacing, status pulses and the modulator.
    always_ff @(posedge i_clk48) begin
        if (!i_rst48_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_level     <= '0;
            frame_cnt   <= '0;
            o_frame     <= 1'b0;
            bus.o_pause <= 1'b0;
            o_underflow <= 1'b0;
            o_overflow  <= 1'b0;
            cur         <= '0;
            acc         <= '0;
            o_dac       <= 1'b0;
        end else begin
            frame_cnt   <= tick ? '0 : frame_cnt + 1'b1;
            o_frame     <= tick;
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            o_level     <= o_level + LW'(wr) - LW'(pop);
            bus.o_pause <= (o_level >= LW'(PAUSE_LEVEL));
            o_underflow <= uflow;
            o_overflow  <= bus.i_pulse && full;
            if (pop) begin
                cur <= mem[rd_ptr];
            end else if (mute) begin
                cur <= '0;
            end
            acc   <= sum[15:0];
            o_dac <= sum[16];
        end
    end

`ifdef SAMPLE_SINK_STATS_EN
    // Saturating event counters, cleared only by reset.
    always_ff @(posedge i_clk48) begin
        if (!i_rst48_n) begin
            o_underflow_cnt <= '0;
            o_overflow_cnt  <= '0;
        end else begin
            if (o_underflow && o_underflow_cnt != 16'hFFFF) begin
                o_underflow_cnt <= o_underflow_cnt + 1'b1;
            end
            if (o_overflow && o_overflow_cnt != 16'hFFFF) begin
                o_overflow_cnt <= o_overflow_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sample_sink_sdm.sv
// Directed bench for sample_sink_sdm (short frames to keep runtime low).
// Expected values are hand-derived from the block behaviour.
module tb_sample_sink_sdm;
    localparam int FC = 64;

    logic       i_clk48 = 1'b0;
    logic       i_rst48_n = 1'b0;
    logic [4:0] o_level;
    logic       o_running;
    logic       o_frame;
    logic       o_underflow;
    logic       o_overflow;
    logic       o_dac;
`ifdef SAMPLE_SINK_STATS_EN
    logic [15:0] ucnt;
    logic [15:0] ocnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    sample_sink_sdm_if bus ();

    sample_sink_sdm #(
        .FIFO_DEPTH   (16),
        .PAUSE_LEVEL  (12),
        .PRIME_LEVEL  (8),
        .FRAME_CYCLES (FC)
    ) dut (
        .i_clk48     (i_clk48),
        .i_rst48_n   (i_rst48_n),
        .bus         (bus.slave),
        .o_level     (o_level),
        .o_running   (o_running),
        .o_frame     (o_frame),
        .o_underflow (o_underflow),
        .o_overflow  (o_overflow),
`ifdef SAMPLE_SINK_STATS_EN
        .o_underflow_cnt (ucnt),
        .o_overflow_cnt  (ocnt),
`endif
        .o_dac       (o_dac)
    );

    always #5 i_clk48 = ~i_clk48;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk48);
        #1;
    endtask

    task automatic pulse(input logic [15:0] s);
        bus.i_sample = s;
        bus.i_pulse  = 1'b1;
        tick();
        bus.i_pulse  = 1'b0;
    endtask

    task automatic do_reset();
        bus.i_pulse = 1'b0;
        i_rst48_n   = 1'b0;
        repeat (2) tick();
        i_rst48_n   = 1'b1;
    endtask

    task automatic wait_frame(input string tag);
        int n = 0;
        tick();
        while (!o_frame && n < 2 * FC + 2) begin
            tick();
            n++;
        end
        check(tag, o_frame, 1'b1);
    endtask

    logic [15:0] vals [8];
    int ones;
    int bad;
    logic prev;

    initial begin
        bus.i_sample = '0;
        bus.i_pulse  = 1'b0;
        vals = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000,
                 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};

        // reset state
        i_rst48_n = 1'b0;
        repeat (2) tick();
        check("rst_level", o_level, 0);
        check("rst_run", o_running, 0);
        check("rst_pause", bus.o_pause, 0);
        check("rst_dac", o_dac, 0);
        check("rst_flags", {o_frame, o_underflow, o_overflow}, 0);
        i_rst48_n = 1'b1;

        // idle: five frames of midscale, no priming
        bad = 0;
        for (int i = 0; i < 5 * FC; i++) begin
            tick();
            if (o_dac !== 1'(i % 2)) bad++;
            if (o_running !== 1'b0 || o_level !== 5'd0) bad++;
            if (bus.o_pause !== 1'b0) bad++;
        end
        check("idle_alt", bad, 0);

        // prime with 8 full-scale samples
        for (int i = 0; i < 8; i++) pulse(16'h7FFF);
        check("prime_lvl8", o_level, 8);
        check("prime_run0", o_running, 0);
        wait_frame("prime_frame");
        check("run_enter", o_running, 1);
        check("run_lvl7", o_level, 7);
        check("run_pause", bus.o_pause, 0);

        // full-scale density: one refill per frame keeps u constant
        ones = 0;
        fork
            begin
                for (int i = 0; i < 65536; i++) begin
                    tick();
                    ones += int'(o_dac);
                end
            end
            begin
                repeat (1024) begin
                    repeat (FC - 1) tick();
                    pulse(16'h7FFF);
                end
            end
        join
        check("ones_7fff", ones, 65535);
        check("ones_still_run", o_running, 1);

        // burst of 17 writes, no boundary in between
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            pulse(16'(k));
            if (k == 12) begin
                check("burst_lvl12", o_level, 12);
                check("burst_pause0", bus.o_pause, 0);
            end
            if (k == 13) check("burst_pause1", bus.o_pause, 1);
            if (k == 16) check("burst_ovf0", o_overflow, 0);
            if (k == 17) begin
                check("ovf_pulse", o_overflow, 1);
                check("ovf_lvl16", o_level, 16);
            end
        end
        tick();
        check("ovf_single", o_overflow, 0);
        check("ovf_lvl_hold", o_level, 16);
`ifdef SAMPLE_SINK_STATS_EN
        check("ovf_cnt", ocnt, 1);
`endif

        // ordering, simultaneous write/pop, drain and underflow
        do_reset();
        for (int i = 0; i < 8; i++) pulse(vals[i]);
        wait_frame("b1");
        check("b1_lvl", o_level, 7);
        wait_frame("b2");
        check("b2_lvl", o_level, 6);
        wait_frame("b3");
        check("b3_lvl", o_level, 5);
        repeat (FC - 1) tick();
        check("pre_coinc_frame", o_frame, 0);
        pulse(16'h7FFF);
        check("coinc_frame", o_frame, 1);
        check("coinc_lvl5", o_level, 5);
        ones = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            ones += int'(o_dac);
        end
        check("oldest_8000", ones, 0);
        for (int b = 5; b <= 8; b++) begin
            wait_frame("drain");
            check("drain_lvl", o_level, 9 - b);
        end
        wait_frame("b9");
        check("b9_lvl0", o_level, 0);
        check("b9_run", o_running, 1);
        check("b9_uf0", o_underflow, 0);
        wait_frame("b10");
        check("uf_pulse", o_underflow, 1);
        check("uf_run0", o_running, 0);
        tick();
        check("uf_single", o_underflow, 0);
        prev = o_dac;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (o_dac === prev) bad++;
            prev = o_dac;
        end
        check("uf_mute_alt", bad, 0);
`ifdef SAMPLE_SINK_STATS_EN
        check("uf_cnt", ucnt, 1);
`endif

        // reset while running with a deep FIFO
        do_reset();
        for (int i = 0; i < 13; i++) pulse(16'h1234);
        wait_frame("deep_frame");
        check("deep_lvl", o_level, 12);
        check("deep_run", o_running, 1);
        tick();
        check("deep_pause", bus.o_pause, 1);
        i_rst48_n = 1'b0;
        tick();
        check("mid_rst_lvl", o_level, 0);
        check("mid_rst_run", o_running, 0);
        check("mid_rst_pause", bus.o_pause, 0);
        check("mid_rst_dac", o_dac, 0);
        i_rst48_n = 1'b1;
        repeat (3) tick();
        check("post_rst_lvl", o_level, 0);
        check("post_rst_run", o_running, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
